// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for mem_ctrl.
// Contents: the read/write op encodings, the FSM state enum, the access-size
// decode, and the byte-lane helpers (write enables, store replication, load
// extract with sign or zero extension).
package mem_pkg;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_LB   = 3'd1,
    RD_LH   = 3'd2,
    RD_LW   = 3'd3,
    RD_LBU  = 3'd4,
    RD_LHU  = 3'd5
  } rd_op_e;

  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_SB   = 2'd1,
    WR_SH   = 2'd2,
    WR_SW   = 2'd3
  } wr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_RD,
    ST_IO_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Only meaningful for legal requests; illegal ones never reach an access.
  function automatic size_e access_size(logic [2:0] rd, logic [1:0] wr);
    case (rd)
      RD_LB, RD_LBU: return SZ_BYTE;
      RD_LH, RD_LHU: return SZ_HALF;
      RD_LW:         return SZ_WORD;
      default: begin
        case (wr)
          WR_SB:   return SZ_BYTE;
          WR_SH:   return SZ_HALF;
          default: return SZ_WORD;
        endcase
      end
    endcase
  endfunction

  function automatic logic [3:0] lane_be(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data so every lane carries it.
  function automatic logic [31:0] store_data(size_e sz, logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(logic [31:0] w, logic [2:0] op,
                                               logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      RD_LB:   return {{24{b[7]}}, b};
      RD_LBU:  return {24'd0, b};
      RD_LH:   return {{16{h[15]}}, h};
      RD_LHU:  return {16'd0, h};
      RD_LW:   return w;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the cpu memory port, mem_ctrl and the memory-mapped IO port.
// slave  : the view mem_ctrl takes (request in, response and IO request out).
// master : the environment view (cpu request out, IO device responses out).
interface mem_ctrl_if;
  logic        mem_init;
  logic [2:0]  mem_read_op;
  logic [1:0]  mem_write_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        fault;
  logic        io_valid;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic        io_ready;
  logic [31:0] io_rdata;

  modport slave (
    input  mem_init, mem_read_op, mem_write_op, addr, wdata,
    output rdata, mem_ready, fault,
    output io_valid, io_we, io_addr, io_wdata, io_be,
    input  io_ready, io_rdata
  );

  modport master (
    output mem_init, mem_read_op, mem_write_op, addr, wdata,
    input  rdata, mem_ready, fault,
    input  io_valid, io_we, io_addr, io_wdata, io_be,
    output io_ready, io_rdata
  );
endinterface

// File: rtl/mem_ctrl_bram.sv
// Word-wide block RAM: one shared address, 4 byte write enables, registered read.
// Ports: clk, addr (word address), be (byte write enables), wdata, rdata (one cycle later).
module mem_bram #(
  parameter int unsigned ADDR_BITS = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [3:0]           be,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-side responder: one strobed request at a time, RISC-V byte/half/word
// loads and stores on internal block RAM or the memory-mapped IO port
// (addr[31]=1), answered with a one-cycle mem_ready pulse.
// Ports: clk, reset (sync, active low), bus (mem_ctrl_if.slave: cpu request,
// rdata/mem_ready/fault response, IO request/response).
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 12,
  parameter string       INIT_FILE  = "",
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(IO_TIMEOUT);

  state_e      state, state_next;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [7:0]  cnt;
  logic [31:0] ram_q;
  logic [3:0]  ram_be;

  size_e       req_size;
  logic        accept, req_illegal, req_misaligned, req_fault, req_io, req_load;
  logic        cnt_hit;
  logic [31:0] req_wdata;

  assign accept         = (state == ST_IDLE) && bus.mem_init;
  assign req_size       = access_size(bus.mem_read_op, bus.mem_write_op);
  assign req_illegal    = ((bus.mem_read_op != RD_NONE) && (bus.mem_write_op != WR_NONE)) ||
                          (bus.mem_read_op >= 3'd6) ||
                          ((bus.mem_read_op == RD_NONE) && (bus.mem_write_op == WR_NONE));
  assign req_misaligned = ((req_size == SZ_HALF) && bus.addr[0]) ||
                          ((req_size == SZ_WORD) && (bus.addr[1:0] != 2'b00));
  assign req_fault      = req_illegal || req_misaligned;
  assign req_io         = bus.addr[31];
  assign req_load       = (bus.mem_read_op != RD_NONE);
  assign req_wdata      = store_data(req_size, bus.wdata);
  assign cnt_hit        = ((cnt + 8'd1) == TIMEOUT_CNT);

  // The RAM address is taken straight from the request so the read or write
  // happens in the accept cycle; bits above the RAM range are dropped.
  mem_bram #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_bram (
    .clk   (clk),
    .addr  (bus.addr[ADDR_BITS+1:2]),
    .be    (ram_be),
    .wdata (req_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_fault)     state_next = ST_DONE;
          else if (req_io)   state_next = ST_IO_WAIT;
          else if (req_load) state_next = ST_RAM_RD;
          else               state_next = ST_DONE;
        end
      end
      ST_RAM_RD:  state_next = ST_DONE;
      ST_IO_WAIT: if (bus.io_ready || cnt_hit) state_next = ST_DONE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Write enables are gated by reset so a store presented in the reset cycle
  // is never committed.
  always_comb begin
    bus.mem_ready = (state == ST_DONE);
    ram_be        = '0;
    if (accept && reset && !req_fault && !req_io && !req_load)
      ram_be = lane_be(req_size, bus.addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q         <= '0;
      lane_q       <= '0;
      cnt          <= '0;
      bus.rdata    <= '0;
      bus.fault    <= 1'b0;
      bus.io_valid <= 1'b0;
      bus.io_we    <= 1'b0;
      bus.io_addr  <= '0;
      bus.io_wdata <= '0;
      bus.io_be    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= bus.mem_read_op;
            lane_q    <= bus.addr[1:0];
            cnt       <= '0;
            bus.rdata <= '0;
            if (req_fault) begin
              bus.fault <= 1'b1;
            end else if (req_io) begin
              bus.io_valid <= 1'b1;
              bus.io_we    <= !req_load;
              bus.io_addr  <= {bus.addr[31:2], 2'b00};
              bus.io_wdata <= req_load ? '0 : req_wdata;
              bus.io_be    <= lane_be(req_size, bus.addr[1:0]);
            end
          end
        end
        ST_RAM_RD: bus.rdata <= load_extract(ram_q, op_q, lane_q);
        ST_IO_WAIT: begin
          if (bus.io_ready) begin
            bus.io_valid <= 1'b0;
            bus.rdata    <= load_extract(bus.io_rdata, op_q, lane_q);
          end else if (cnt_hit) begin
            bus.io_valid <= 1'b0;
            bus.fault    <= 1'b1;
            bus.rdata    <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_ctrl_if bus ();

  mem_ctrl #(
    .ADDR_BITS  (12),
    .INIT_FILE  (""),
    .IO_TIMEOUT (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Issue one request and wait for mem_ready; lat counts cycles after the accept edge.
  task automatic do_req(input logic [2:0] rd, input logic [1:0] wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdv);
    @(negedge clk);
    bus.mem_init     = 1'b1;
    bus.mem_read_op  = rd;
    bus.mem_write_op = wr;
    bus.addr         = a;
    bus.wdata        = d;
    lat = 0;
    do begin
      @(negedge clk);
      bus.mem_init = 1'b0;
      lat++;
    end while (bus.mem_ready !== 1'b1 && lat < 400);
    rdv = bus.rdata;
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout addr=%h: no mem_ready within %0d cycles", a, lat);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL req_pulse_width addr=%h: mem_ready=%b, required 0", a, bus.mem_ready);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rdata !== 32'h0 || bus.mem_ready !== 1'b0 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: rdata=%h ready=%b fault=%b, required 0/0/0",
               bus.rdata, bus.mem_ready, bus.fault);
    end
    checks++;
    if (bus.io_valid !== 1'b0 || bus.io_we !== 1'b0 || bus.io_addr !== 32'h0 ||
        bus.io_wdata !== 32'h0 || bus.io_be !== 4'h0) begin
      errors++;
      $display("FAIL reset_io: valid=%b we=%b addr=%h wdata=%h be=%h, required all 0",
               bus.io_valid, bus.io_we, bus.io_addr, bus.io_wdata, bus.io_be);
    end
    reset = 1'b1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] r;
    do_req(3'd0, 2'd3, 32'h100, 32'h12345678, lat, r);
    checks++;
    if (lat !== 1 || r !== 32'h0) begin
      errors++; $display("FAIL sw_0x100: lat=%0d rdata=%h, required 1/00000000", lat, r);
    end
    do_req(3'd3, 2'd0, 32'h100, 32'h0, lat, r);
    checks++;
    if (lat !== 2 || r !== 32'h12345678) begin
      errors++; $display("FAIL lw_0x100: lat=%0d rdata=%h, required 2/12345678", lat, r);
    end
  endtask

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  task automatic test_lanes();
    vec_t v [9];
    int lat; logic [31:0] r;
    v[0] = '{3'd0, 2'd1, 32'h103, 32'h000000AB, 1, 32'h0};
    v[1] = '{3'd1, 2'd0, 32'h103, 32'h0, 2, 32'hFFFFFFAB};
    v[2] = '{3'd4, 2'd0, 32'h103, 32'h0, 2, 32'h000000AB};
    v[3] = '{3'd3, 2'd0, 32'h100, 32'h0, 2, 32'hAB345678};
    v[4] = '{3'd2, 2'd0, 32'h102, 32'h0, 2, 32'hFFFFAB34};
    v[5] = '{3'd5, 2'd0, 32'h100, 32'h0, 2, 32'h00005678};
    v[6] = '{3'd0, 2'd2, 32'h100, 32'h00008001, 1, 32'h0};
    v[7] = '{3'd1, 2'd0, 32'h101, 32'h0, 2, 32'hFFFFFF80};
    v[8] = '{3'd3, 2'd0, 32'h4100, 32'h0, 2, 32'hAB348001};
    for (int i = 0; i < 9; i++) begin
      do_req(v[i].rd, v[i].wr, v[i].a, v[i].d, lat, r);
      checks++;
      if (lat !== v[i].lat || r !== v[i].exp) begin
        errors++;
        $display("FAIL lanes[%0d] rd=%0d wr=%0d addr=%h: lat=%0d rdata=%h, required %0d/%h",
                 i, v[i].rd, v[i].wr, v[i].a, lat, r, v[i].lat, v[i].exp);
      end
    end
  endtask

  task automatic test_io_load();
    @(negedge clk);
    bus.mem_init = 1'b1; bus.mem_read_op = 3'd3; bus.mem_write_op = 2'd0;
    bus.addr = 32'h80000004; bus.wdata = 32'h0;
    @(negedge clk);
    bus.mem_init = 1'b0;
    checks++;
    if (bus.io_valid !== 1'b1 || bus.io_we !== 1'b0 || bus.io_addr !== 32'h80000004 ||
        bus.io_be !== 4'hF) begin
      errors++;
      $display("FAIL io_load_req: valid=%b we=%b addr=%h be=%h, required 1/0/80000004/f",
               bus.io_valid, bus.io_we, bus.io_addr, bus.io_be);
    end
    @(negedge clk);
    @(negedge clk);
    bus.io_ready = 1'b1; bus.io_rdata = 32'hCAFEF00D;
    checks++;
    if (bus.mem_ready !== 1'b0 || bus.io_valid !== 1'b1) begin
      errors++;
      $display("FAIL io_load_wait: ready=%b valid=%b, required 0/1", bus.mem_ready, bus.io_valid);
    end
    @(negedge clk);
    bus.io_ready = 1'b0; bus.io_rdata = 32'h0;
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.io_valid !== 1'b0 || bus.rdata !== 32'hCAFEF00D ||
        bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL io_load_done: ready=%b valid=%b rdata=%h fault=%b, required 1/0/cafef00d/0",
               bus.mem_ready, bus.io_valid, bus.rdata, bus.fault);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_ready !== 1'b0) begin
      errors++; $display("FAIL io_load_pulse: ready=%b, required 0", bus.mem_ready);
    end
  endtask

  task automatic test_io_timeout();
    int n = 0;
    @(negedge clk);
    bus.mem_init = 1'b1; bus.mem_read_op = 3'd0; bus.mem_write_op = 2'd2;
    bus.addr = 32'h80000002; bus.wdata = 32'h0000BEEF;
    @(negedge clk);
    bus.mem_init = 1'b0;
    checks++;
    if (bus.io_we !== 1'b1 || bus.io_addr !== 32'h80000000 || bus.io_be !== 4'hC ||
        bus.io_wdata !== 32'hBEEFBEEF) begin
      errors++;
      $display("FAIL io_sh_req: we=%b addr=%h be=%h wdata=%h, required 1/80000000/c/beefbeef",
               bus.io_we, bus.io_addr, bus.io_be, bus.io_wdata);
    end
    while (bus.io_valid === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 255) begin
      errors++; $display("FAIL io_timeout_len: io_valid cycles=%0d, required 255", n);
    end
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.fault !== 1'b1 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL io_timeout_done: ready=%b fault=%b rdata=%h, required 1/1/00000000",
               bus.mem_ready, bus.fault, bus.rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] r;
    apply_reset();
    checks++;
    if (bus.fault !== 1'b0) begin
      errors++; $display("FAIL fault_cleared: fault=%b, required 0", bus.fault);
    end
    do_req(3'd2, 2'd0, 32'h101, 32'h0, lat, r);
    checks++;
    if (lat !== 1 || r !== 32'h0 || bus.fault !== 1'b1) begin
      errors++;
      $display("FAIL lh_misaligned: lat=%0d rdata=%h fault=%b, required 1/00000000/1", lat, r, bus.fault);
    end
    do_req(3'd0, 2'd3, 32'h102, 32'hFFFFFFFF, lat, r);
    checks++;
    if (lat !== 1 || r !== 32'h0) begin
      errors++; $display("FAIL sw_misaligned: lat=%0d rdata=%h, required 1/00000000", lat, r);
    end
    do_req(3'd3, 2'd0, 32'h100, 32'h0, lat, r);
    checks++;
    if (lat !== 2 || r !== 32'hAB348001 || bus.fault !== 1'b1) begin
      errors++;
      $display("FAIL ram_unchanged: lat=%0d rdata=%h fault=%b, required 2/ab348001/1", lat, r, bus.fault);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] rd [3];
    logic [1:0] wr [3];
    int lat; logic [31:0] r;
    rd[0] = 3'd6; wr[0] = 2'd0;
    rd[1] = 3'd3; wr[1] = 2'd3;
    rd[2] = 3'd0; wr[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      apply_reset();
      do_req(rd[i], wr[i], 32'h100, 32'h0, lat, r);
      checks++;
      if (lat !== 1 || r !== 32'h0 || bus.fault !== 1'b1) begin
        errors++;
        $display("FAIL illegal[%0d] rd=%0d wr=%0d: lat=%0d rdata=%h fault=%b, required 1/00000000/1",
                 i, rd[i], wr[i], lat, r, bus.fault);
      end
    end
    do_req(3'd3, 2'd0, 32'h100, 32'h0, lat, r);
    checks++;
    if (r !== 32'hAB348001) begin
      errors++; $display("FAIL illegal_no_write: rdata=%h, required ab348001", r);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] r;
    @(negedge clk);
    bus.mem_init = 1'b1; bus.mem_read_op = 3'd0; bus.mem_write_op = 2'd3;
    bus.addr = 32'h80000010; bus.wdata = 32'h11223344;
    @(negedge clk);
    bus.mem_init = 1'b0;
    checks++;
    if (bus.io_valid !== 1'b1 || bus.io_wdata !== 32'h11223344) begin
      errors++;
      $display("FAIL mid_req: valid=%b wdata=%h, required 1/11223344", bus.io_valid, bus.io_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.io_valid !== 1'b0 || bus.mem_ready !== 1'b0 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ready=%b fault=%b, required 0/0/0",
               bus.io_valid, bus.mem_ready, bus.fault);
    end
    reset = 1'b1;
    do_req(3'd3, 2'd0, 32'h100, 32'h0, lat, r);
    checks++;
    if (lat !== 2 || r !== 32'hAB348001) begin
      errors++; $display("FAIL mid_idle: lat=%0d rdata=%h, required 2/ab348001", lat, r);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] r;
    do_req(3'd0, 2'd3, 32'h200, 32'hDEADBEEF, lat, r);
    do_req(3'd5, 2'd0, 32'h202, 32'h0, lat, r);
    checks++;
    if (lat !== 2 || r !== 32'h0000DEAD) begin
      errors++; $display("FAIL b2b_lhu: lat=%0d rdata=%h, required 2/0000dead", lat, r);
    end
    do_req(3'd1, 2'd0, 32'h200, 32'h0, lat, r);
    checks++;
    if (r !== 32'hFFFFFFEF) begin
      errors++; $display("FAIL b2b_lb: rdata=%h, required ffffffef", r);
    end
  endtask

  initial begin
    bus.mem_init = 1'b0; bus.mem_read_op = 3'd0; bus.mem_write_op = 2'd0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.io_ready = 1'b0; bus.io_rdata = 32'h0;
    test_reset();
    test_word();
    test_lanes();
    test_io_load();
    test_io_timeout();
    test_misaligned();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
